// File: rtl/cim_psum_accumulator.sv
// rtl/cim_psum_accumulator.sv - shift-add accumulator of bit-serial CIM column psums
module cim_psum_accumulator #(
    parameter int NUM_COLS   = 32,
    parameter int PSUM_WIDTH = 21,
    parameter int NUM_PASSES = 8,
    parameter int SIGNED_IN  = 1,
    parameter int ACC_WIDTH  = PSUM_WIDTH + NUM_PASSES,
    localparam int PASS_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            clear,
    input  logic [NUM_COLS*PSUM_WIDTH-1:0]  psum_in,
    input  logic                            psum_ready,
    output logic                            psum_ack,
    output logic [NUM_COLS*ACC_WIDTH-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [PASS_W-1:0]               pass_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t                                state_q, state_d;
    logic [PASS_W-1:0]                     pass_q, pass_d;
    logic [NUM_COLS-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                                  last_pass;
    logic                                  sub_pass;

    // Sign-extend one column psum to full precision and weight it by its bit plane.
    function automatic logic [ACC_WIDTH-1:0] weighted(
        input logic [PSUM_WIDTH-1:0] p,
        input logic [PASS_W-1:0]     sh
    );
        logic [ACC_WIDTH-1:0] ext;
        ext = ACC_WIDTH'($signed(p));
        return ext << sh;
    endfunction

    assign last_pass = (pass_q == LAST_PASS);
    // With signed activations the MSB plane carries weight -2^(N-1).
    assign sub_pass  = (SIGNED_IN != 0) && last_pass;

    assign out_data = acc_q;
    assign pass_idx = pass_q;

    // State, pass counter and accumulators; reset leaves everything idle and zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, accumulate and handshake outputs; clear overrides every state.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        acc_d     = acc_q;
        psum_ack  = 1'b0;
        out_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
        if (clear) begin
            state_d = ST_IDLE;
            pass_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ACC;
                        pass_d  = '0;
                        acc_d   = '0;
                    end
                end
                ST_ACC: begin
                    psum_ack = psum_ready;
                    if (psum_ready) begin
                        for (int k = 0; k < NUM_COLS; k++) begin
                            if (sub_pass) begin
                                acc_d[k] = acc_q[k] - weighted(psum_in[k*PSUM_WIDTH +: PSUM_WIDTH], pass_q);
                            end else begin
                                acc_d[k] = acc_q[k] + weighted(psum_in[k*PSUM_WIDTH +: PSUM_WIDTH], pass_q);
                            end
                        end
                        if (last_pass) begin
                            state_d = ST_OUT;
                            pass_d  = '0;
                        end else begin
                            pass_d  = pass_q + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pass_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_psum_accumulator.sv
// tb/tb_cim_psum_accumulator.sv - directed checks of cim_psum_accumulator, unsigned and signed builds
module tb_cim_psum_accumulator;

    localparam int NC  = 32;
    localparam int PSW = 21;
    localparam int NP  = 8;
    localparam int A   = PSW + NP;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 clear;
    logic [NC*PSW-1:0]    psum_in;
    logic                 psum_ready;
    logic                 out_ready;

    logic                 ack_u, ack_s;
    logic [NC*A-1:0]      out_data_u, out_data_s;
    logic                 out_valid_u, out_valid_s;
    logic                 busy_u, busy_s;
    logic [2:0]           pass_idx_u, pass_idx_s;

    int tests  = 0;
    int failed = 0;
    int acks_u = 0;
    int acks_s = 0;
    int base_u;
    int base_s;

    logic [PSW-1:0] c0_v [NP];
    logic [PSW-1:0] c1_v [NP];

    always #5 clk = ~clk;

    cim_psum_accumulator #(.NUM_COLS(NC), .PSUM_WIDTH(PSW), .NUM_PASSES(NP), .SIGNED_IN(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .psum_in(psum_in), .psum_ready(psum_ready), .psum_ack(ack_u),
        .out_data(out_data_u), .out_valid(out_valid_u), .out_ready(out_ready),
        .busy(busy_u), .pass_idx(pass_idx_u)
    );

    cim_psum_accumulator #(.NUM_COLS(NC), .PSUM_WIDTH(PSW), .NUM_PASSES(NP), .SIGNED_IN(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .psum_in(psum_in), .psum_ready(psum_ready), .psum_ack(ack_s),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .busy(busy_s), .pass_idx(pass_idx_s)
    );

    // Inputs only change just after the rising edge, so an ack seen at the falling edge is consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack_u) acks_u++;
            if (ack_s) acks_s++;
        end
    end

    function automatic logic [A-1:0] ucol(input int k);
        return out_data_u[k*A +: A];
    endfunction

    function automatic logic [A-1:0] scol(input int k);
        return out_data_s[k*A +: A];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input logic [A-1:0] obs, input logic [A-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_col(input int k, input logic [PSW-1:0] v);
        psum_in[k*PSW +: PSW] = v;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present the eight vectors from c0_v/c1_v; toggle=1 idles psum_ready every other cycle.
    task automatic feed(input bit toggle);
        int p;
        int cyc;
        p   = 0;
        cyc = 0;
        while (p < NP && cyc < 40) begin
            set_col(0, c0_v[p]);
            set_col(1, c1_v[p]);
            psum_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (psum_ready && p == NP - 1) begin
                chk("out_valid before last accept", 32'(out_valid_u), 32'd0);
            end
            @(posedge clk); #1;
            if (psum_ready) p++;
            cyc++;
        end
        psum_ready = 1'b0;
        chk("feed completed passes", 32'(p), 32'(NP));
        chk("out_valid after last accept", 32'(out_valid_u), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain busy", 32'(busy_u), 32'd0);
        chk("drain out_valid", 32'(out_valid_s), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        psum_in    = '0;
        psum_ready = 1'b1;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid_u), 32'd0);
        chk("reset busy", 32'(busy_s), 32'd0);
        chk("reset pass_idx", 32'(pass_idx_u), 32'd0);
        chk("reset psum_ack", 32'({ack_u, ack_s}), 32'd0);
        chk_acc("reset acc col0", ucol(0), A'(0));
        psum_ready = 1'b0;
        rst_n      = 1'b1;

        // Reset in the middle of an accumulation
        psum_in = '0;
        set_col(0, PSW'(1));
        do_start();
        psum_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid-acc pass_idx", 32'(pass_idx_s), 32'd3);
        chk("mid-acc busy", 32'(busy_u), 32'd1);
        psum_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid_u), 32'd0);
        chk("async reset busy", 32'({busy_u, busy_s}), 32'd0);
        chk("async reset pass_idx", 32'(pass_idx_u), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unsigned build: col0 = 1 on every plane gives 255
        for (int i = 0; i < NP; i++) begin
            c0_v[i] = PSW'(1);
            c1_v[i] = '0;
        end
        psum_in = '0;
        do_start();
        base_u = acks_u;
        feed(1'b0);
        chk("t2 ack count", 32'(acks_u - base_u), 32'd8);
        chk("t2 pass_idx wrap", 32'(pass_idx_u), 32'd0);
        chk_acc("t2 uns col0", ucol(0), A'(255));
        chk_acc("t2 uns col1", ucol(1), A'(0));
        chk_acc("t2 uns col5", ucol(5), A'(0));
        chk_acc("t2 sgn col0", scol(0), A'(-1));
        drain();

        // Signed build: MSB plane subtracts; large negative psum on the MSB plane only
        c1_v[NP-1] = 21'h100001;
        do_start();
        base_s = acks_s;
        feed(1'b0);
        chk("t3 ack count", 32'(acks_s - base_s), 32'd8);
        chk_acc("t3 sgn col0", scol(0), A'(-1));
        chk_acc("t3 sgn col1", scol(1), A'(134217600));
        chk_acc("t3 uns col1", ucol(1), A'(-134217600));
        drain();

        // psum_ready stalls on alternate cycles, col0 = pass+1, col1 = -3
        for (int i = 0; i < NP; i++) begin
            c0_v[i] = PSW'(i + 1);
            c1_v[i] = 21'h1FFFFD;
        end
        do_start();
        base_u = acks_u;
        feed(1'b1);
        chk("t4 ack count", 32'(acks_u - base_u), 32'd8);
        chk_acc("t4 uns col0", ucol(0), A'(1793));
        chk_acc("t4 sgn col0", scol(0), A'(-255));
        chk_acc("t4 uns col1", ucol(1), A'(-765));
        chk_acc("t4 sgn col1", scol(1), A'(3));

        // Downstream back-pressure: result held, start and psum traffic ignored
        for (int i = 0; i < 5; i++) begin
            start      = 1'b1;
            psum_ready = 1'b1;
            set_col(0, PSW'($urandom));
            @(posedge clk); #1;
            chk("t4 hold out_valid", 32'(out_valid_u), 32'd1);
            chk_acc("t4 hold uns col0", ucol(0), A'(1793));
            chk_acc("t4 hold sgn col1", scol(1), A'(3));
        end
        start      = 1'b0;
        psum_ready = 1'b0;
        chk("t4 no acks in OUT", 32'(acks_u - base_u), 32'd8);
        drain();

        // Abort with clear at pass 4, then a clean accumulation
        psum_in = '0;
        set_col(0, PSW'(5));
        do_start();
        base_u = acks_u;
        psum_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5 pass_idx before clear", 32'(pass_idx_u), 32'd4);
        clear = 1'b1;
        #1;
        chk("t5 ack during clear", 32'({ack_u, ack_s}), 32'd0);
        @(posedge clk); #1;
        clear      = 1'b0;
        psum_ready = 1'b0;
        chk("t5 busy after clear", 32'(busy_s), 32'd0);
        chk("t5 pass_idx after clear", 32'(pass_idx_u), 32'd0);
        chk("t5 acks before clear", 32'(acks_u - base_u), 32'd4);
        for (int i = 0; i < NP; i++) begin
            c0_v[i] = PSW'(2);
            c1_v[i] = '0;
        end
        do_start();
        feed(1'b0);
        chk_acc("t5 uns col0", ucol(0), A'(510));
        chk_acc("t5 sgn col0", scol(0), A'(-2));
        chk_acc("t5 uns col1", ucol(1), A'(0));
        drain();

        // Back-to-back results with every handshake ready: 20 cycles for two results
        base_u    = acks_u;
        psum_in   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * (NP + 2); i++) begin
            start      = (i == 0) || (i == NP + 2);
            psum_ready = 1'b1;
            set_col(0, (i < NP + 2) ? PSW'(3) : PSW'(7));
            #1;
            if (i == NP + 1) begin
                chk("t6 first out_valid", 32'(out_valid_u), 32'd1);
                chk_acc("t6 first uns col0", ucol(0), A'(765));
                chk_acc("t6 first sgn col0", scol(0), A'(-3));
            end
            if (i == NP + 2) begin
                chk("t6 idle between results", 32'(busy_u), 32'd0);
            end
            if (i == 2 * (NP + 2) - 1) begin
                chk("t6 second out_valid", 32'(out_valid_s), 32'd1);
                chk_acc("t6 second uns col0", ucol(0), A'(1785));
                chk_acc("t6 second sgn col0", scol(0), A'(-7));
            end
            @(posedge clk); #1;
        end
        start      = 1'b0;
        psum_ready = 1'b0;
        out_ready  = 1'b0;
        chk("t6 idle at end", 32'(busy_u), 32'd0);
        chk("t6 ack count", 32'(acks_u - base_u), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
